// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI A2D master.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, FRONT, SHIFT, BACK} spi_state_t;

  localparam int SCLK_W_DEF = 5;
  localparam int DATA_W_DEF = 16;

  // Divider start value: SCLK high, with a front porch of a quarter SCLK period before the first fall
  function automatic int preload(input int w);
    return (1 << (w - 1)) + (1 << (w - 2)) - 1;
  endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// SCLK divider: free-runs outside IDLE, is parked at PRELOAD otherwise,
// and flags the clk before each SCLK rise and fall.
module spi_sclk_div
  import spi_pkg::*;
#(
  parameter int SCLK_W = SCLK_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              reload,
  output logic              sclk,
  output logic              rise_imm,
  output logic              fall_imm,
  output logic [SCLK_W-1:0] div
);

  localparam logic [SCLK_W-1:0] PRELOAD = SCLK_W'(preload(SCLK_W));

  // Divider counter; parked at PRELOAD so SCLK idles high
  always_ff @(posedge clk) begin
    if (rst || hold || reload) div <= PRELOAD;
    else                       div <= div + 1'b1;
  end

  assign sclk     = div[SCLK_W-1];
  assign rise_imm = (div == {1'b0, {(SCLK_W-1){1'b1}}});
  assign fall_imm = (div == {SCLK_W{1'b1}});

endmodule

// File: rtl/spi_adc_master.sv
// SPI mode-3 master for an ADC128S-style A2D: 16-bit full-duplex transfers.
// Optional build macro SPI_BACK_PORCH_EN: holds SS_n low a quarter SCLK period
// after the final shift before raising SS_n and done together.
//
// state | meaning
// IDLE  | SS_n high, SCLK parked high, waiting for wrt
// FRONT | SS_n low, front porch; the first SCLK fall carries no shift
// SHIFT | shifting on each SCLK fall until DATA_W-1 shifts are done
// BACK  | wait for the last rise, final shift, optional back porch, finish
module spi_adc_master
  import spi_pkg::*;
#(
  parameter int SCLK_W = SCLK_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt,
  input  logic [DATA_W-1:0] wt_data,
  output logic              SS_n,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              done,
  output logic [DATA_W-1:0] rd_data
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [SCLK_W-1:0] DIV_LAST_RISE = {1'b1, {(SCLK_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_PENULT    = CNT_W'(DATA_W - 2);
  localparam logic [CNT_W-1:0]  CNT_LAST      = CNT_W'(DATA_W - 1);
`ifdef SPI_BACK_PORCH_EN
  localparam logic [SCLK_W-1:0] DIV_PORCH_END = SCLK_W'((1 << (SCLK_W - 1)) + (1 << (SCLK_W - 2)));
  localparam logic [CNT_W-1:0]  CNT_ALL       = CNT_W'(DATA_W);
`endif

  spi_state_t        state, nxt_state;
  logic [SCLK_W-1:0] div;
  logic              rise_imm, fall_imm;
  logic              load, shift, finish;
  logic              smpl;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shft_reg;

  spi_sclk_div #(.SCLK_W(SCLK_W)) u_sclk_div (
    .clk      (clk),
    .rst      (rst),
    .hold     (state == IDLE),
    .reload   (finish),
    .sclk     (SCLK),
    .rise_imm (rise_imm),
    .fall_imm (fall_imm),
    .div      (div)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  // Next-state logic
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:  if (wrt) nxt_state = FRONT;
      FRONT: if (fall_imm) nxt_state = SHIFT;
      SHIFT: if (fall_imm && (bit_cnt == CNT_PENULT)) nxt_state = BACK;
      BACK:  if (finish) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Datapath strobes decoded from state and divider position
  always_comb begin
    load   = 1'b0;
    shift  = 1'b0;
    finish = 1'b0;
    case (state)
      IDLE:  load  = wrt;
      SHIFT: shift = fall_imm;
      BACK: begin
        // the last bit was sampled on the rise just before; shift it in now
        shift = (div == DIV_LAST_RISE) && (bit_cnt == CNT_LAST);
`ifdef SPI_BACK_PORCH_EN
        finish = (div == DIV_PORCH_END) && (bit_cnt == CNT_ALL);
`else
        finish = shift;
`endif
      end
      default: ;
    endcase
  end

  // Shift register, MISO sample, bit counter, SS_n and done
  always_ff @(posedge clk) begin
    if (rst) begin
      shft_reg <= '0;
      smpl     <= 1'b0;
      bit_cnt  <= '0;
      SS_n     <= 1'b1;
      done     <= 1'b0;
    end else begin
      if (rise_imm) smpl <= MISO;
      if (load) begin
        shft_reg <= wt_data;
        bit_cnt  <= '0;
        SS_n     <= 1'b0;
        done     <= 1'b0;
      end else if (shift) begin
        shft_reg <= {shft_reg[DATA_W-2:0], smpl};
        bit_cnt  <= bit_cnt + 1'b1;
      end
      if (finish) begin
        SS_n <= 1'b1;
        done <= 1'b1;
      end
    end
  end

  assign MOSI    = shft_reg[DATA_W-1];
  assign rd_data = shft_reg;

endmodule

// File: tb/tb_spi_adc_master.sv
// Bench for spi_adc_master against an ADC128S-style slave that answers each
// command with the previous complete command (first answer 16'hABCD).
// Honours SPI_BACK_PORCH_EN for the expected SS_n-low window length.
module tb_spi_adc_master;

  typedef struct packed {
    logic [15:0] rd;
    logic [15:0] cmd;
  } exp_t;

`ifdef SPI_BACK_PORCH_EN
  localparam int EXP_LAT = 514;
`else
  localparam int EXP_LAT = 506;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wrt = 1'b0;
  logic [15:0] wt_data = 16'h0;
  logic        MISO = 1'b0;
  logic        SS_n, SCLK, MOSI, done;
  logic [15:0] rd_data;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   t_fall = 0;
  exp_t sb[$];

  // slave model state
  logic [15:0] slv_tx = 16'h0;
  logic [15:0] slv_rx = 16'h0;
  logic [15:0] slv_cmd = 16'h0;
  logic [15:0] slv_resp = 16'hABCD;
  int          rises = 0;
  int          falls = 0;
  int          windows = 0;
  int          sclk_edges = 0;
  logic        ss_q = 1'b1;
  logic        sclk_q = 1'b1;

  spi_adc_master dut (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt),
    .wt_data (wt_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .done    (done),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(SCLK) sclk_edges++;

  // Slave: samples MOSI on rises, skips the first fall, shifts MISO on later falls
  always @(SS_n or SCLK) begin
    if (ss_q === 1'b1 && SS_n === 1'b0) begin
      slv_tx = slv_resp;
      MISO   = slv_tx[15];
      rises  = 0;
      falls  = 0;
      windows++;
    end else if (ss_q === 1'b0 && SS_n === 1'b1) begin
      if (rises == 16) begin
        slv_cmd  = slv_rx;
        slv_resp = slv_rx;
      end
    end
    if (SS_n === 1'b0 && sclk_q === 1'b0 && SCLK === 1'b1) begin
      slv_rx = {slv_rx[14:0], MOSI};
      rises++;
    end
    if (SS_n === 1'b0 && sclk_q === 1'b1 && SCLK === 1'b0) begin
      falls++;
      if (falls > 1) begin
        slv_tx = slv_tx << 1;
        MISO   = slv_tx[15];
      end
    end
    ss_q   = SS_n;
    sclk_q = SCLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // call at a negedge; drives wrt for one clk and checks SS_n/done one clk later
  task automatic start_xfer(input string tag, input logic [15:0] d, input logic push,
                            input logic [15:0] rd, input logic [15:0] cmd);
    exp_t e;
    wrt     = 1'b1;
    wt_data = d;
    if (push) begin
      e.rd  = rd;
      e.cmd = cmd;
      sb.push_back(e);
    end
    @(negedge clk);
    wrt = 1'b0;
    chk({tag, "_ss_low"}, 32'(SS_n), 32'd0);
    chk({tag, "_done_low"}, 32'(done), 32'd0);
    t_fall = cyc;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    int   lat;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    lat = cyc - t_fall;
    chk({tag, "_latency"}, 32'(lat), 32'(EXP_LAT));
    chk({tag, "_ss_high"}, 32'(SS_n), 32'd1);
    chk({tag, "_rises"}, 32'(rises), 32'd16);
    chk({tag, "_falls"}, 32'(falls), 32'd16);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_rd_data"}, 32'(rd_data), 32'(e.rd));
      chk({tag, "_slave_cmd"}, 32'(slv_cmd), 32'(e.cmd));
    end else begin
      chk({tag, "_sb_entry"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    int e0;
    int w0;

    // reset held for 3 clk
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ss", 32'(SS_n), 32'd1);
    chk("reset_sclk", 32'(SCLK), 32'd1);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_rd", 32'(rd_data), 32'h0000);
    rst = 1'b0;
    e0 = sclk_edges;
    repeat (20) @(negedge clk);
    chk("idle_sclk_edges", 32'(sclk_edges - e0), 32'd0);

    // first read
    start_xfer("t1", 16'hC000, 1'b1, 16'hABCD, 16'hC000);
    wait_done("t1");

    // back-to-back, with an ignored wrt mid-transfer
    w0 = windows;
    start_xfer("t2", 16'h1234, 1'b1, 16'hC000, 16'h1234);
    repeat (100) @(negedge clk);
    wrt     = 1'b1;
    wt_data = 16'hFFFF;
    @(negedge clk);
    wrt = 1'b0;
    chk("t2_busy_done_low", 32'(done), 32'd0);
    wait_done("t2");
    chk("t2_windows", 32'(windows - w0), 32'd1);

    // abort by reset 200 clk into a transfer
    start_xfer("t3", 16'h5A5A, 1'b0, 16'h0, 16'h0);
    repeat (199) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ss", 32'(SS_n), 32'd1);
    chk("abort_sclk", 32'(SCLK), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    rst = 1'b0;

    // normal transfer after the abort
    start_xfer("t4", 16'h0F0F, 1'b1, 16'h1234, 16'h0F0F);
    wait_done("t4");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
